// File: rtl/fwd_ctrl.sv
// Forwarding and load-use controller for a 5-stage pipeline.
// Tracks the destination tags of the MEM and WB instructions. From them it
// drives the ALU operand mux selects, flags load-use hazards, and counts
// forwarding cycles.
module fwd_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  en,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  output logic [1:0]            sel_a,
  output logic [1:0]            sel_b,
  output logic                  stall,
  output logic [CNT_W-1:0]      fwd_cnt
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_wr;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  wb_wr;
  logic                  fwd_any;

  // MEM holds the newer value, so it wins over WB; r0 is hardwired and never forwards
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] m_rd,
    input logic                  m_wr,
    input logic [REG_ADDR_W-1:0] w_rd,
    input logic                  w_wr
  );
    if (m_wr && (m_rd != '0) && (m_rd == rs)) begin
      return SEL_MEM;
    end
    if (w_wr && (w_rd != '0) && (w_rd == rs)) begin
      return SEL_WB;
    end
    return SEL_RF;
  endfunction

  // Saturating increment: sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  // Operand selects, load-use detection and the "any forwarding" event
  always_comb begin
    sel_a   = fwd_sel(ex_rs1, mem_rd, mem_wr, wb_rd, wb_wr);
    sel_b   = fwd_sel(ex_rs2, mem_rd, mem_wr, wb_rd, wb_wr);
    fwd_any = (sel_a != SEL_RF) || (sel_b != SEL_RF);
    stall   = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
              ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

  // Stage tags: a flush turns the MEM slot into a bubble even while stalled;
  // WB only advances when the pipeline advances
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mem_rd <= '0;
      mem_wr <= 1'b0;
      wb_rd  <= '0;
      wb_wr  <= 1'b0;
    end else begin
      if (en) begin
        wb_rd <= mem_rd;
        wb_wr <= mem_wr;
      end
      if (flush) begin
        mem_wr <= 1'b0;
      end else if (en) begin
        mem_rd <= ex_rd;
        mem_wr <= ex_reg_write;
      end
    end
  end

  // Forwarding-event counter: one count per advancing cycle with any forward
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      fwd_cnt <= '0;
    end else if (en && fwd_any) begin
      fwd_cnt <= sat_inc(fwd_cnt);
    end
  end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Bench for fwd_ctrl: directed scenarios followed by random traffic, with a
// model that tracks the two older instructions as a small history array.
module tb_fwd_ctrl;

  logic       clk = 1'b0;
  logic       arst;
  logic       en;
  logic       flush;
  logic [4:0] ex_rd;
  logic       ex_reg_write;
  logic       ex_mem_read;
  logic [4:0] ex_rs1;
  logic [4:0] ex_rs2;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;

  logic [1:0]  sel_a, sel_b, sel_a2, sel_b2;
  logic        stall, stall2;
  logic [15:0] fwd_cnt;
  logic [1:0]  fwd_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .arst(arst), .en(en), .flush(flush),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .sel_a(sel_a), .sel_b(sel_b), .stall(stall), .fwd_cnt(fwd_cnt)
  );

  fwd_ctrl #(.REG_ADDR_W(5), .CNT_W(2)) dut_sat (
    .clk(clk), .arst(arst), .en(en), .flush(flush),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .sel_a(sel_a2), .sel_b(sel_b2), .stall(stall2), .fwd_cnt(fwd_cnt2)
  );

  // Reference model: hist[0] is the instruction one ahead of EX, hist[1] two ahead
  typedef struct {
    logic [4:0] rd;
    logic       wr;
  } tag_t;

  tag_t        hist[2];
  int unsigned m_cnt16;
  int unsigned m_cnt2;

  function automatic logic [1:0] m_sel(input logic [4:0] rs);
    for (int i = 0; i < 2; i++) begin
      if (hist[i].wr && hist[i].rd != 0 && hist[i].rd == rs) return 2'(i + 1);
    end
    return 2'b00;
  endfunction

  function automatic logic m_stall();
    return ex_mem_read && ex_reg_write && ex_rd != 0 &&
           (ex_rd == id_rs1 || ex_rd == id_rs2);
  endfunction

  task automatic m_clear();
    hist[0] = '{rd: 5'd0, wr: 1'b0};
    hist[1] = '{rd: 5'd0, wr: 1'b0};
    m_cnt16 = 0;
    m_cnt2  = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".sel_a"}, 32'(sel_a), 32'(m_sel(ex_rs1)));
    check({tag, ".sel_b"}, 32'(sel_b), 32'(m_sel(ex_rs2)));
    check({tag, ".stall"}, 32'(stall), 32'(m_stall()));
    check({tag, ".cnt16"}, 32'(fwd_cnt), m_cnt16);
    check({tag, ".cnt2"}, 32'(fwd_cnt2), m_cnt2);
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge
  task automatic tick();
    tag_t n0, n1;
    logic any;
    any = en && (m_sel(ex_rs1) != 0 || m_sel(ex_rs2) != 0);
    n0 = hist[0];
    n1 = hist[1];
    if (en) begin
      n1 = hist[0];
      n0 = '{rd: ex_rd, wr: ex_reg_write && !flush};
    end else if (flush) begin
      n0.wr = 1'b0;
    end
    @(posedge clk);
    #1;
    if (arst) begin
      m_clear();
    end else begin
      hist[0] = n0;
      hist[1] = n1;
      if (any) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  endtask

  task automatic idle();
    en = 1'b1; flush = 1'b0; ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
    ex_rs1 = 0; ex_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    #1;
    m_clear();
    tick();
    arst = 1'b0;
    #1;
  endtask

  int unsigned held_cnt;

  initial begin
    arst = 1'b0;
    idle();
    m_clear();
    do_reset();
    check_all("after_reset");

    // Back-to-back dependency: 01 then 10, two counted cycles
    ex_rd = 5; ex_reg_write = 1; tick();
    ex_reg_write = 0; ex_rd = 0; ex_rs1 = 5; #1;
    check("b2b.mem", 32'(sel_a), 32'd1);
    tick();
    check("b2b.wb", 32'(sel_a), 32'd2);
    tick();
    ex_rs1 = 0; #1;
    check("b2b.cnt", 32'(fwd_cnt), 32'd2);
    check_all("b2b");

    // MEM-over-WB priority, both operands counted once
    do_reset();
    ex_rd = 7; ex_reg_write = 1; tick(); tick();
    ex_reg_write = 0; ex_rd = 0; ex_rs1 = 7; ex_rs2 = 7; #1;
    check("prio.a", 32'(sel_a), 32'd1);
    check("prio.b", 32'(sel_b), 32'd1);
    tick();
    check("prio.cnt", 32'(fwd_cnt), 32'd1);
    check_all("prio");

    // r0 never forwards
    do_reset();
    ex_rd = 0; ex_reg_write = 1; tick();
    ex_reg_write = 0; ex_rs1 = 0; #1;
    check("r0.sel", 32'(sel_a), 32'd0);

    // Hold with en=0: tags and counter frozen
    ex_rd = 5; ex_reg_write = 1; ex_rs1 = 0; tick();
    ex_rs1 = 5; tick();
    held_cnt = 32'(fwd_cnt);
    en = 0; ex_rd = 6;
    for (int i = 0; i < 3; i++) tick();
    check("hold.sel", 32'(sel_a), 32'd1);
    check("hold.cnt", 32'(fwd_cnt), held_cnt);
    check_all("hold");
    idle();

    // Load-use
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3; id_rs2 = 3; #1;
    check("lu.hit", 32'(stall), 32'd1);
    id_rs2 = 4; #1;
    check("lu.miss", 32'(stall), 32'd0);
    idle();

    // Flush bubble
    do_reset();
    ex_rd = 9; ex_reg_write = 1; flush = 1; tick();
    flush = 0; ex_reg_write = 0; ex_rd = 0; ex_rs1 = 9; #1;
    check("flush.mem", 32'(sel_a), 32'd0);
    tick();
    check("flush.wb", 32'(sel_a), 32'd0);
    check_all("flush");

    // Saturation of the 2-bit counter
    do_reset();
    ex_rd = 1; ex_reg_write = 1; tick();
    ex_rs1 = 1;
    for (int i = 0; i < 5; i++) tick();
    check("sat.cnt2", 32'(fwd_cnt2), 32'd3);
    check("sat.cnt16", 32'(fwd_cnt), 32'd5);

    // Asynchronous reset mid-operation discards tags immediately
    @(negedge clk);
    arst = 1; ex_rs1 = 1; ex_rs2 = 1; id_rs1 = 1; ex_mem_read = 1; #1;
    check("arst.sel_a", 32'(sel_a), 32'd0);
    check("arst.sel_b", 32'(sel_b), 32'd0);
    check("arst.cnt", 32'(fwd_cnt), 32'd0);
    check("arst.stall", 32'(stall), 32'd1);
    m_clear();
    tick();
    arst = 0; #1;
    check_all("arst_rel");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      en           = ($urandom_range(0, 9) < 8);
      flush        = ($urandom_range(0, 9) == 0);
      ex_rd        = 5'($urandom_range(0, 7));
      ex_reg_write = 1'($urandom);
      ex_mem_read  = 1'($urandom);
      ex_rs1       = 5'($urandom_range(0, 7));
      ex_rs2       = 5'($urandom_range(0, 7));
      id_rs1       = 5'($urandom_range(0, 7));
      id_rs2       = 5'($urandom_range(0, 7));
      #1;
      check_all("rand");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
